// File: rtl/drop_controller.sv
// Connect-4 drop sequencer and board store: accepts a move, animates the fall, commits the piece.
// Define DROP_ANIM_EN for the row-by-row fall animation; without it a piece lands right after accept.
module drop_controller #(
  parameter int ROWS        = 6,
  parameter int COLS        = 7,
  parameter int TICK_CYCLES = 12_500_000
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     make_move,
  input  logic                     player,
  input  logic [2:0]               sel_col,
  output logic                     valid_col,
  output logic                     busy,
  output logic                     landed,
  output logic                     anim_active,
  output logic [2:0]               anim_row,
  output logic [2:0]               anim_col,
  output logic                     anim_player,
  output logic [2*ROWS*COLS-1:0]   board,
  output logic [2:0]               last_row,
  output logic [2:0]               last_col,
  output logic                     board_full
);

  localparam int CELLS = ROWS * COLS;

  if (TICK_CYCLES < 1) begin : g_tick_check
    $error("drop_controller: TICK_CYCLES must be at least 1");
  end

`ifdef DROP_ANIM_EN
  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_CYCLES - 1);
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
`ifdef DROP_ANIM_EN
    ST_FALL  = 2'd3,
`endif
    ST_PLACE = 2'd1,
    ST_LAND  = 2'd2
  } state_t;

  state_t             state_r;
  logic [2:0]         col_r;
  logic [2:0]         target_r;
  logic               player_r;
  logic [2:0]         anim_row_r;
  logic [2:0]         last_row_r;
  logic [2:0]         last_col_r;
  logic               busy_r;
  logic               landed_r;
  logic               anim_active_r;
  logic [2*CELLS-1:0] board_r;
`ifdef DROP_ANIM_EN
  logic [CW-1:0]      cnt_r;
`endif

  logic [2:0]         target_row_s;
  logic               col_top_empty_s;
  logic               valid_col_s;
  logic               board_full_s;

  // Landing row (lowest empty cell) and top-cell occupancy of the selected column.
  always_comb begin
    target_row_s    = 3'd0;
    col_top_empty_s = 1'b0;
    for (int c = 0; c < COLS; c++) begin
      if (sel_col == 3'(c)) begin
        col_top_empty_s = (board_r[2*c +: 2] == 2'b00);
        for (int r = 0; r < ROWS; r++) begin
          if (board_r[2*(r*COLS+c) +: 2] == 2'b00) begin
            target_row_s = 3'(r);
          end else begin
            target_row_s = target_row_s;
          end
        end
      end else begin
        col_top_empty_s = col_top_empty_s;
      end
    end
  end

  // The board is full once every top-row cell holds a piece.
  always_comb begin
    board_full_s = 1'b1;
    for (int c = 0; c < COLS; c++) begin
      board_full_s = board_full_s & (board_r[2*c +: 2] != 2'b00);
    end
  end

  assign valid_col_s = (state_r == ST_IDLE) && ({1'b0, sel_col} < 4'(COLS)) && col_top_empty_s;

  // Drop sequencer: accept, fall, commit the piece, then pulse landed.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      col_r         <= 3'd0;
      target_r      <= 3'd0;
      player_r      <= 1'b0;
      anim_row_r    <= 3'd0;
      last_row_r    <= 3'd0;
      last_col_r    <= 3'd0;
      busy_r        <= 1'b0;
      landed_r      <= 1'b0;
      anim_active_r <= 1'b0;
      board_r       <= '0;
`ifdef DROP_ANIM_EN
      cnt_r         <= '0;
`endif
    end else begin
      landed_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (make_move && valid_col_s) begin
            col_r         <= sel_col;
            target_r      <= target_row_s;
            player_r      <= player;
            busy_r        <= 1'b1;
            anim_active_r <= 1'b1;
`ifdef DROP_ANIM_EN
            anim_row_r    <= 3'd0;
            cnt_r         <= '0;
            state_r       <= ST_FALL;
`else
            anim_row_r    <= target_row_s;
            state_r       <= ST_PLACE;
`endif
          end
        end
`ifdef DROP_ANIM_EN
        ST_FALL: begin
          if (cnt_r == TICK_LAST) begin
            if (anim_row_r == target_r) begin
              state_r <= ST_PLACE;
            end else begin
              anim_row_r <= anim_row_r + 3'd1;
              cnt_r      <= '0;
            end
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
`endif
        ST_PLACE: begin
          for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
              if (target_r == 3'(r) && col_r == 3'(c)) begin
                board_r[2*(r*COLS+c) +: 2] <= player_r ? 2'b10 : 2'b01;
              end
            end
          end
          last_row_r    <= target_r;
          last_col_r    <= col_r;
          landed_r      <= 1'b1;
          anim_active_r <= 1'b0;
          state_r       <= ST_LAND;
        end
        ST_LAND: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r        <= 1'b0;
          anim_active_r <= 1'b0;
          state_r       <= ST_IDLE;
        end
      endcase
    end
  end

  assign valid_col   = valid_col_s;
  assign busy        = busy_r;
  assign landed      = landed_r;
  assign anim_active = anim_active_r;
  assign anim_row    = anim_row_r;
  assign anim_col    = col_r;
  assign anim_player = player_r;
  assign board       = board_r;
  assign last_row    = last_row_r;
  assign last_col    = last_col_r;
  assign board_full  = board_full_s;

endmodule

// File: tb/tb_drop_controller.sv
// Directed bench for drop_controller (TICK_CYCLES=4); adapts expected latency to DROP_ANIM_EN.
module tb_drop_controller;

  localparam int TICKS = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        make_move;
  logic        player;
  logic [2:0]  sel_col;
  logic        valid_col;
  logic        busy;
  logic        landed;
  logic        anim_active;
  logic [2:0]  anim_row;
  logic [2:0]  anim_col;
  logic        anim_player;
  logic [83:0] board;
  logic [2:0]  last_row;
  logic [2:0]  last_col;
  logic        board_full;

  logic [83:0] exp_board;
  int          n_checks = 0;
  int          n_fail   = 0;

  drop_controller #(.ROWS(6), .COLS(7), .TICK_CYCLES(TICKS)) dut (
    .clock(clock), .reset(reset), .make_move(make_move), .player(player),
    .sel_col(sel_col), .valid_col(valid_col), .busy(busy), .landed(landed),
    .anim_active(anim_active), .anim_row(anim_row), .anim_col(anim_col),
    .anim_player(anim_player), .board(board), .last_row(last_row),
    .last_col(last_col), .board_full(board_full)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] exp_anim_row(input int k, input logic [2:0] row);
`ifdef DROP_ANIM_EN
    if (k / TICKS >= int'(row)) return row;
    return 3'(k / TICKS);
`else
    return row + 3'd0 + 3'(k * 0);
`endif
  endfunction

  function automatic int exp_latency(input logic [2:0] row);
`ifdef DROP_ANIM_EN
    return (int'(row) + 1) * TICKS + 1;
`else
    return 1 + int'(row) * 0;
`endif
  endfunction

  // One drop; hold keeps make_move high until landed, and player is flipped after accept.
  task automatic do_drop(input logic [2:0] c, input logic p, input logic [2:0] row, input logic hold);
    int k;
    int lat;
    lat = exp_latency(row);
    @(negedge clock);
    sel_col = c; player = p; make_move = 1'b1;
    #1 check("valid_col_open", valid_col, 1'b1);
    @(negedge clock);
    if (!hold) make_move = 1'b0;
    player = ~p;
    k = 0;
    while (k <= lat + 4 && !landed) begin
      check("busy_in_drop", busy, 1'b1);
      check("anim_active", anim_active, 1'b1);
      check("anim_row", anim_row, exp_anim_row(k, row));
      check("anim_col", anim_col, c);
      check("anim_player", anim_player, p);
      @(negedge clock);
      k++;
    end
    check("latency", k, lat);
    exp_board[2*(int'(row)*7 + int'(c)) +: 2] = p ? 2'b10 : 2'b01;
    check("board", board, exp_board);
    check("last_row", last_row, row);
    check("last_col", last_col, c);
    check("anim_active_land", anim_active, 1'b0);
    make_move = 1'b0;
    @(negedge clock);
    check("landed_one_cycle", landed, 1'b0);
    check("busy_after", busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    int n_landed;
    logic [2:0] rst_row;
    reset = 1'b1; make_move = 1'b0; player = 1'b0; sel_col = 3'd3;
    exp_board = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Reset state.
    check("rst_busy", busy, 1'b0);
    check("rst_landed", landed, 1'b0);
    check("rst_anim_active", anim_active, 1'b0);
    check("rst_anim_row", anim_row, 3'd0);
    check("rst_last_row", last_row, 3'd0);
    check("rst_last_col", last_col, 3'd0);
    check("rst_board", board, 84'd0);
    check("rst_board_full", board_full, 1'b0);
    check("rst_valid_col", valid_col, 1'b1);

    // Out-of-range column is never accepted.
    sel_col = 3'd7; make_move = 1'b1;
    #1 check("col7_valid", valid_col, 1'b0);
    @(negedge clock);
    check("col7_busy", busy, 1'b0);
    make_move = 1'b0;

    // Empty-board drop.
    do_drop(3'd3, 1'b0, 3'd5, 1'b0);

    // Column fill with alternating players; one drop holds make_move.
    for (int i = 0; i < 6; i++) begin
      do_drop(3'd0, 1'(i % 2), 3'(5 - i), (i == 2) ? 1'b1 : 1'b0);
    end
    @(negedge clock);
    sel_col = 3'd0; make_move = 1'b1;
    #1 check("full_col_valid", valid_col, 1'b0);
    @(negedge clock);
    check("full_col_busy", busy, 1'b0);
    make_move = 1'b0;
    @(negedge clock);
    check("full_col_board", board, exp_board);

    // Reset mid-fall discards the piece.
`ifdef DROP_ANIM_EN
    rst_row = 3'd2;
`else
    rst_row = 3'd5;
`endif
    sel_col = 3'd1; player = 1'b1; make_move = 1'b1;
    @(negedge clock);
    make_move = 1'b0;
    k = 0;
    while (!(busy && anim_row == rst_row) && k < 100) begin
      @(negedge clock);
      k++;
    end
    check("reached_rst_row", anim_row, rst_row);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    exp_board = '0;
    check("midrst_busy", busy, 1'b0);
    check("midrst_board", board, 84'd0);
    check("midrst_anim_active", anim_active, 1'b0);
    check("midrst_last_row", last_row, 3'd0);
    check("midrst_landed", landed, 1'b0);
    n_landed = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (landed) n_landed++;
    end
    check("midrst_no_landed", n_landed, 0);

    // Fill the whole board.
    for (int c = 0; c < 7; c++) begin
      for (int r = 0; r < 6; r++) begin
        if (c == 6 && r == 5) check("not_full_yet", board_full, 1'b0);
        do_drop(3'(c), 1'((c + r) % 2), 3'(5 - r), 1'b0);
      end
    end
    check("board_full", board_full, 1'b1);
    for (int c = 0; c < 7; c++) begin
      sel_col = 3'(c);
      #1 check("full_valid_col", valid_col, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
